// File: rtl/ch_seq_pkg.sv
// Shared types and default constants for the channel playback sequencer.
package ch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    WR_DRAIN,
    RD_REQ,
    PLAY,
    FINISH
  } seq_state_t;

  localparam int BURST_MAX_DEF = 8;
  localparam int WR_THRESH_DEF = 128;

endpackage

// File: rtl/seq_addr_cnt.sv
// Tracks the current replay address and words remaining; derives the next burst
// length and whether it is the final burst of the sequence.
module seq_addr_cnt
  import ch_seq_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 16,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  total_i,
  output logic [ADDR_W-1:0] cur_addr_o,
  output logic [CNT_W-1:0]  burst_o,
  output logic              last_burst_o
);

  localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(BURST_MAX);

  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;

  always_comb begin
    burst_o      = (remaining_q > BURST_MAX_C) ? BURST_MAX_C : remaining_q;
    last_burst_o = (remaining_q <= BURST_MAX_C);
  end

  // Address advance wraps naturally at the ADDR_W boundary.
  always_comb begin
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    if (load_i) begin
      cur_addr_d  = base_addr_i;
      remaining_d = total_i;
    end else if (advance_i) begin
      cur_addr_d  = cur_addr_q + ADDR_W'(burst_o);
      remaining_d = remaining_q - burst_o;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
    end else begin
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
    end
  end

  assign cur_addr_o = cur_addr_q;

endmodule

// File: rtl/playback_sequencer.sv
// Splits a channel replay into read bursts, drives halfDuplex/playbackUnit handshakes
// and grants write drains at burst boundaries. All outputs are registered.
module playback_sequencer
  import ch_seq_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 16,
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int WR_THRESH = WR_THRESH_DEF
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [CNT_W-1:0]  totalWords,
  input  logic [8:0]        wrCount,
  input  logic              dataValid,
  input  logic              playDone,
  output logic              readReq,
  output logic              writeReq,
  output logic [ADDR_W-1:0] requestAddr,
  output logic [CNT_W-1:0]  numReads,
  output logic              playEnable,
  output logic              busy,
  output logic              done
);

  localparam logic [8:0] WR_THRESH_C = 9'(WR_THRESH);

  seq_state_t state_q, state_d;

  logic              load, advance, ld_burst;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  burst;
  logic              last_burst;

  logic              read_req_q, read_req_d;
  logic              write_req_q, write_req_d;
  logic              play_en_q, play_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [CNT_W-1:0]  num_reads_q, num_reads_d;

  seq_addr_cnt #(
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W),
    .BURST_MAX(BURST_MAX)
  ) u_addr_cnt (
    .clk         (clk),
    .resetN      (resetN),
    .load_i      (load),
    .advance_i   (advance),
    .base_addr_i (baseAddr),
    .total_i     (totalWords),
    .cur_addr_o  (cur_addr),
    .burst_o     (burst),
    .last_burst_o(last_burst)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    advance  = 1'b0;
    ld_burst = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (totalWords == '0) ? FINISH : ARB;
        end
      end
      ARB: begin
        if (wrCount >= WR_THRESH_C) begin
          state_d = WR_DRAIN;
        end else begin
          ld_burst = 1'b1;
          state_d  = RD_REQ;
        end
      end
      WR_DRAIN: if (dataValid) state_d = ARB;
      RD_REQ:   if (dataValid) state_d = PLAY;
      PLAY: begin
        if (playDone) begin
          advance = 1'b1;
          state_d = last_burst ? FINISH : ARB;
        end
      end
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Abort overrides everything, including a start seen in IDLE.
    if (abort) begin
      state_d  = IDLE;
      load     = 1'b0;
      advance  = 1'b0;
      ld_burst = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they are valid in the state they describe.
  always_comb begin
    read_req_d  = (state_d == RD_REQ);
    write_req_d = (state_d == WR_DRAIN);
    play_en_d   = (state_d == PLAY);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FINISH);
    req_addr_d  = ld_burst ? cur_addr : req_addr_q;
    num_reads_d = ld_burst ? burst : num_reads_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      read_req_q  <= 1'b0;
      write_req_q <= 1'b0;
      play_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_addr_q  <= '0;
      num_reads_q <= '0;
    end else begin
      state_q     <= state_d;
      read_req_q  <= read_req_d;
      write_req_q <= write_req_d;
      play_en_q   <= play_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_addr_q  <= req_addr_d;
      num_reads_q <= num_reads_d;
    end
  end

  assign readReq     = read_req_q;
  assign writeReq    = write_req_q;
  assign playEnable  = play_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign requestAddr = req_addr_q;
  assign numReads    = num_reads_q;

endmodule
